mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It sits in the EX stage beside the ALU and is driven by the main controller FSM, which issues a start pulse, operands and the M-extension func3. The controller holds in EX until done, then writes the result back.
The unit computes one bit per cycle (shift-add for multiply, restoring division for divide), so latency is fixed and independent of operands.

---
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle. Shift-add is
// used for multiply and restoring division for divide, so latency is fixed.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_CALC, ST_DONE} state_t;

  state_t              state, state_next;
  logic [2:0]          op;
  logic [XLEN-1:0]     opa, opb;
  logic [XLEN-1:0]     mag;
  logic [2*XLEN-1:0]   acc;
  logic [CNT_W-1:0]    counter;
  logic                neg_q, neg_r;
  logic                special;
  logic [XLEN-1:0]     special_val;

  logic                is_div, last;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic                div_zero, overflow;
  logic [XLEN-1:0]     special_next;
  logic [XLEN:0]       add_sum, shifted, diff;
  logic [2*XLEN-1:0]   acc_step, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, final_val;

  assign is_div = op[2];
  assign last   = (counter == CNT_W'(XLEN-1));

  // Operand sign handling and special-case detection used by PREP.
  always_comb begin
    a_signed     = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                   (op == 3'b100) || (op == 3'b110);
    b_signed     = (op == 3'b000) || (op == 3'b001) ||
                   (op == 3'b100) || (op == 3'b110);
    a_neg        = a_signed && opa[XLEN-1];
    b_neg        = b_signed && opb[XLEN-1];
    a_abs        = a_neg ? -opa : opa;
    b_abs        = b_neg ? -opb : opb;
    div_zero     = (opb == '0);
    overflow     = !op[0] && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
    special_next = '0;
    if (div_zero)
      special_next = op[1] ? opa : '1;
    else if (overflow)
      special_next = op[1] ? '0 : opa;
  end

  // One iteration: multiply adds into the upper half and shifts right; divide
  // shifts the dividend bit into the remainder and keeps the trial difference
  // whenever it does not go negative.
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag : {XLEN{1'b0}})};
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = shifted - {1'b0, mag};
    acc_step = {add_sum, acc[XLEN-1:1]};
    if (is_div) begin
      if (!diff[XLEN])
        acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_step = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op)
      3'b000:          final_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          final_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:  final_val = quo_fix;
      default:         final_val = rem_fix;
    endcase
    if (special)
      final_val = special_val;
  end

  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    case (state)
      ST_IDLE: if (start) state_next = ST_PREP;
      ST_PREP: state_next = ST_CALC;
      ST_CALC: if (last) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op          <= '0;
      opa         <= '0;
      opb         <= '0;
      mag         <= '0;
      acc         <= '0;
      counter     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
      result      <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op  <= func3;
            opa <= rs1;
            opb <= rs2;
          end
        end
        ST_PREP: begin
          // Divide keeps the divisor in mag and the dividend in the low half.
          mag         <= is_div ? b_abs : a_abs;
          acc         <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
          neg_q       <= a_neg ^ b_neg;
          neg_r       <= a_neg;
          special     <= is_div && (div_zero || overflow);
          special_val <= special_next;
          counter     <= '0;
        end
        ST_CALC: begin
          acc     <= acc_step;
          counter <= counter + 1'b1;
          if (last)
            result <= final_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-level reference model built on
// plain 64-bit arithmetic, plus directed vectors with hand-computed results.
module tb_mul_div_unit;

  localparam int XLEN = 32;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  bit          chk_en = 1'b0;
  int          model_left = 0;
  logic [31:0] model_res = '0;
  logic [31:0] model_pend = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func3  (func3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Architectural result of one M-extension operation.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      MUL:     begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
      MULH:    begin p = sa * sb;                 return p[63:32]; end
      MULHSU:  begin p = sa * ub;                 return p[63:32]; end
      MULHU:   begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV:     begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:     begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timing model: an accepted start keeps the unit busy for XLEN+2 cycles,
  // the last of which is the done cycle, when the new result appears.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_left = 0;
      model_res  = '0;
    end else if (model_left == 0) begin
      if (start) begin
        model_left = XLEN + 2;
        model_pend = model(func3, rs1, rs2);
      end
    end else begin
      model_left = model_left - 1;
      if (model_left == 1)
        model_res = model_pend;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected)
      pass_cnt++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_busy",   {31'b0, busy}, {31'b0, (model_left > 0)});
      checkOutput("model_done",   {31'b0, done}, {31'b0, (model_left == 1)});
      checkOutput("model_result", result, model_res);
    end
  end

  // Issue one request; afterwards the inputs are scrambled to show they are
  // not re-sampled once the request is accepted.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    func3 = f;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    func3 = ~f;
    rs1   = ~a;
    rs2   = ~b;
  endtask

  task automatic waitDone(output int edges, output int busy_n);
    edges  = 0;
    busy_n = busy ? 1 : 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_n++;
    end
    if (!done)
      checkOutput("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected);
    int edges, busy_n;
    applyStimulus(f, a, b);
    waitDone(edges, busy_n);
    checkOutput({name, "_result"}, result, expected);
    checkOutput({name, "_latency"}, edges, 32'd33);
    checkOutput({name, "_busy_cycles"}, busy_n, 32'd34);
    @(posedge clk); #1;
    checkOutput({name, "_done_1cyc"}, {31'b0, done}, 32'd0);
    checkOutput({name, "_idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    checkOutput("reset_busy",   {31'b0, busy}, 32'd0);
    checkOutput("reset_done",   {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOp("mul_neg",     MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    runOp("mulh_min",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    runOp("mulhu_max",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("mulhsu_max",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("mulh_small",  MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
    runOp("mulhsu_m2x3", MULHSU, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
    runOp("mul_m2x3",    MUL,    32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA);
    runOp("mulhu_shift", MULHU,  32'h8000_0000, 32'd4,         32'd2);
    runOp("div_m7_2",    DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    runOp("rem_m7_2",    REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    runOp("div_7_m2",    DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    runOp("rem_7_m2",    REM,    32'd7,         32'hFFFF_FFFE, 32'd1);
    runOp("divu_100_7",  DIVU,   32'd100,       32'd7,         32'd14);
    runOp("remu_100_7",  REMU,   32'd100,       32'd7,         32'd2);
    runOp("remu_big",    REMU,   32'hFFFF_FFFF, 32'h10,        32'hF);
    runOp("divu_by0",    DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
    runOp("remu_by0",    REMU,   32'd5,         32'd0,         32'd5);
    runOp("div_by0",     DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    runOp("rem_by0",     REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    runOp("div_ovf",     DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("rem_ovf",     REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Starts while busy (mid-calculation and during the done cycle) are dropped.
    applyStimulus(DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    func3 = MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ignore_done_seen", {31'b0, done}, 32'd1);
    checkOutput("ignore_result", result, 32'd14);
    func3 = MUL; rs1 = 32'd1; rs2 = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("ignore_done_low", {31'b0, done}, 32'd0);
    checkOutput("ignore_not_busy", {31'b0, busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ignore_hold_result", result, 32'd14);
    checkOutput("ignore_hold_done", {31'b0, done}, 32'd0);

    // Reset mid-operation aborts without a done pulse.
    applyStimulus(MUL, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",   {31'b0, busy}, 32'd0);
    checkOutput("abort_done",   {31'b0, done}, 32'd0);
    checkOutput("abort_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    checkOutput("abort_no_done", n, 32'd0);
    runOp("mul_after_rst", MUL, 32'd3, 32'd4, 32'd12);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
